mmu_xlat_req_ctrl: RTL

Translation request controller that sits directly upstream of the MMU stub in the Ara/CVA6 integration. It accepts virtual-address requests from the vector load/store unit over a valid/ready handshake and drives the MMU request interface, holding the request until the MMU answers. It buffers the resulting physical address and exception in a small response FIFO that the requester drains with its own handshake. A page fault or a watchdog timeout halts the block until the requester issues a flush.

---
 rtl/mmu_xlat_req_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/mmu_xlat_req_ctrl.sv
// mmu_xlat_req_ctrl: translation request controller in front of the MMU stub.
// Accepts virtual-address requests over a valid/ready handshake, either bypasses
// them straight into the response FIFO or holds a request on the MMU interface
// until it answers, and halts on a page fault or watchdog timeout until flushed.
//
// Handshake semantics (both request and response sides): a transfer happens in
// the cycle where valid and ready are both high at the rising clock edge. ready
// never depends on valid, and a valid source holds its payload until the transfer.
//
// rsp_ex_o / mmu_exception_i are flat vectors laid out like ariane_pkg::exception_t
// ({cause, tval, valid}, valid in bit 0), so the packed struct connects directly.
// dbg_state_o exposes the FSM state (0 IDLE, 1 WAIT, 2 HALT).
module mmu_xlat_req_ctrl #(
    parameter int unsigned VLEN          = 64,
    parameter int unsigned PLEN          = 56,
    parameter int unsigned ExW           = 129,
    parameter int unsigned RspDepth      = 2,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_translation_i,
    input  logic            flush_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [VLEN-1:0] req_vaddr_i,
    input  logic            req_is_store_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [PLEN-1:0] rsp_paddr_o,
    output logic [ExW-1:0]  rsp_ex_o,
    output logic            mmu_req_o,
    output logic [VLEN-1:0] mmu_vaddr_o,
    output logic            mmu_is_store_o,
    input  logic            mmu_valid_i,
    input  logic [PLEN-1:0] mmu_paddr_i,
    input  logic [ExW-1:0]  mmu_exception_i,
    output logic            busy_o,
    output logic            timeout_o,
    output logic [1:0]      dbg_state_o
);

    localparam int CntW = $clog2(RspDepth + 1);
    localparam int PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     wait_cnt_q, wait_cnt_d;
    logic [VLEN-1:0] vaddr_q, vaddr_d;
    logic            is_store_q, is_store_d;

    logic [PLEN-1:0] paddr_mem_q [RspDepth];
    logic [PLEN-1:0] paddr_mem_d [RspDepth];
    logic [ExW-1:0]  ex_mem_q    [RspDepth];
    logic [ExW-1:0]  ex_mem_d    [RspDepth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic            push;
    logic            pop;
    logic [PLEN-1:0] push_paddr;
    logic [ExW-1:0]  push_ex;
    logic [PLEN-1:0] bypass_paddr;
    logic            req_ready;
    logic            timeout;

    // Bypass address: zero-extend or truncate the virtual address to PLEN.
    if (PLEN <= VLEN) begin : g_trunc
        assign bypass_paddr = req_vaddr_i[PLEN-1:0];
    end else begin : g_ext
        assign bypass_paddr = {{(PLEN - VLEN){1'b0}}, req_vaddr_i};
    end

    // FSM next-state, request capture, watchdog and FIFO push selection.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        vaddr_d    = vaddr_q;
        is_store_d = is_store_q;
        push       = 1'b0;
        push_paddr = '0;
        push_ex    = '0;
        timeout    = 1'b0;
        // A flush cycle never accepts a request, so nothing is lost when it wipes state.
        req_ready  = (state_q == ST_IDLE) && (count_q < CntW'(RspDepth)) && !flush_i;

        if (flush_i) begin
            state_d    = ST_IDLE;
            wait_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i && req_ready) begin
                        vaddr_d    = req_vaddr_i;
                        is_store_d = req_is_store_i;
                        if (en_translation_i) begin
                            state_d    = ST_WAIT;
                            wait_cnt_d = '0;
                        end else begin
                            push       = 1'b1;
                            push_paddr = bypass_paddr;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_q != '1) begin
                        wait_cnt_d = wait_cnt_q + 32'd1;
                    end
                    // The slot for this push was reserved at acceptance and the
                    // count can only shrink while waiting, so it cannot overflow.
                    if (mmu_valid_i) begin
                        push       = 1'b1;
                        push_paddr = mmu_paddr_i;
                        push_ex    = mmu_exception_i;
                        state_d    = mmu_exception_i[0] ? ST_HALT : ST_IDLE;
                    end else if ((TimeoutCycles != 0) &&
                                 (wait_cnt_q == 32'(TimeoutCycles - 1))) begin
                        timeout = 1'b1;
                        state_d = ST_HALT;
                    end
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Response FIFO pointers, count and storage; flush empties it outright.
    always_comb begin
        paddr_mem_d = paddr_mem_q;
        ex_mem_d    = ex_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pop         = (count_q != '0) && rsp_ready_i;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                paddr_mem_d[wr_ptr_q] = push_paddr;
                ex_mem_d[wr_ptr_q]    = push_ex;
                wr_ptr_d = (wr_ptr_q == PtrW'(RspDepth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PtrW'(RspDepth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // All state flops, cleared asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            vaddr_q     <= '0;
            is_store_q  <= 1'b0;
            paddr_mem_q <= '{default: '0};
            ex_mem_q    <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            vaddr_q     <= vaddr_d;
            is_store_q  <= is_store_d;
            paddr_mem_q <= paddr_mem_d;
            ex_mem_q    <= ex_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Outputs decoded from registers; only flush can drop the MMU request early.
    always_comb begin
        req_ready_o    = req_ready;
        rsp_valid_o    = (count_q != '0);
        rsp_paddr_o    = rsp_valid_o ? paddr_mem_q[rd_ptr_q] : '0;
        rsp_ex_o       = rsp_valid_o ? ex_mem_q[rd_ptr_q] : '0;
        mmu_req_o      = (state_q == ST_WAIT) && !flush_i;
        mmu_vaddr_o    = vaddr_q;
        mmu_is_store_o = is_store_q;
        busy_o         = (state_q != ST_IDLE) || (count_q != '0);
        timeout_o      = timeout;
        dbg_state_o    = state_q;
    end

endmodule
